// File: rtl/pipe_stage_regs.sv
// Fetch PC, F/D and D/E pipeline registers driven by the load-use hazard unit's
// stall and bubble commands, with saturating stall/bubble performance counters.

`ifndef INOP
`define INOP 6'h00
`endif
`ifndef RNONE
`define RNONE 5'h00
`endif

module pipe_stage_regs #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             F_stall,
    input  logic             D_stall,
    input  logic             E_bubble,
    input  logic [31:0]      f_pc_next,
    input  logic [31:0]      f_instr,
    output logic [31:0]      F_pc,
    output logic [31:0]      D_instr,
    output logic [31:0]      D_pc,
    input  logic [5:0]       d_op,
    input  logic [4:0]       d_dstE,
    input  logic [4:0]       d_dstM,
    input  logic [31:0]      d_valA,
    input  logic [31:0]      d_valB,
    input  logic [31:0]      d_imm,
    output logic [5:0]       E_op,
    output logic [4:0]       E_dstE,
    output logic [4:0]       E_dstM,
    output logic [31:0]      E_valA,
    output logic [31:0]      E_valB,
    output logic [31:0]      E_imm,
    output logic [31:0]      E_pc,
    output logic             E_valid,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [31:0]      r_F_pc;
    logic [31:0]      r_D_instr;
    logic [31:0]      r_D_pc;
    logic [5:0]       r_E_op;
    logic [4:0]       r_E_dstE;
    logic [4:0]       r_E_dstM;
    logic [31:0]      r_E_valA;
    logic [31:0]      r_E_valB;
    logic [31:0]      r_E_imm;
    logic [31:0]      r_E_pc;
    logic             r_E_valid;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_F_pc    <= RESET_PC;
            r_D_instr <= 32'h0;
            r_D_pc    <= RESET_PC;
        end else begin
            if (!F_stall) begin
                r_F_pc <= f_pc_next;
            end
            if (!D_stall) begin
                r_D_instr <= f_instr;
                r_D_pc    <= r_F_pc;
            end
        end
    end

    // D/E is never held: each edge it takes either a bubble or the decode outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_E_op    <= `INOP;
            r_E_dstE  <= `RNONE;
            r_E_dstM  <= `RNONE;
            r_E_valA  <= 32'h0;
            r_E_valB  <= 32'h0;
            r_E_imm   <= 32'h0;
            r_E_pc    <= RESET_PC;
            r_E_valid <= 1'b0;
        end else begin
            r_E_pc <= r_D_pc;
            if (E_bubble) begin
                r_E_op    <= `INOP;
                r_E_dstE  <= `RNONE;
                r_E_dstM  <= `RNONE;
                r_E_valA  <= 32'h0;
                r_E_valB  <= 32'h0;
                r_E_imm   <= 32'h0;
                r_E_valid <= 1'b0;
            end else begin
                r_E_op    <= d_op;
                r_E_dstE  <= d_dstE;
                r_E_dstM  <= d_dstM;
                r_E_valA  <= d_valA;
                r_E_valB  <= d_valB;
                r_E_imm   <= d_imm;
                r_E_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (D_stall && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
            if (E_bubble && (r_bubble_cnt != CNT_MAX)) begin
                r_bubble_cnt <= r_bubble_cnt + CNT_ONE;
            end
        end
    end

    assign F_pc       = r_F_pc;
    assign D_instr    = r_D_instr;
    assign D_pc       = r_D_pc;
    assign E_op       = r_E_op;
    assign E_dstE     = r_E_dstE;
    assign E_dstM     = r_E_dstM;
    assign E_valA     = r_E_valA;
    assign E_valB     = r_E_valB;
    assign E_imm      = r_E_imm;
    assign E_pc       = r_E_pc;
    assign E_valid    = r_E_valid;
    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_pipe_stage_regs.sv
// Bench for pipe_stage_regs: hand-computed vector table, closed-loop load-use and
// corner sequences, then randomized traffic against a pipeline-state reference model.

module tb_pipe_stage_regs;

    localparam logic [31:0] RESET_PC = 32'h0000_0040;
    localparam int          CNT_W    = 4;
    localparam int          CNT_MAX  = (1 << CNT_W) - 1;
    localparam logic [5:0]  OP_NOP   = 6'h00;
    localparam logic [5:0]  OP_ADD   = 6'h01;
    localparam logic [5:0]  OP_LW    = 6'h23;
    localparam logic [4:0]  R_NONE   = 5'h00;

    typedef struct packed {
        logic        fs;
        logic        ds;
        logic        eb;
        logic [31:0] pcNext;
        logic [31:0] instr;
        logic [5:0]  op;
        logic [4:0]  dstE;
        logic [4:0]  dstM;
        logic [31:0] valA;
        logic [31:0] valB;
        logic [31:0] imm;
    } inp_t;

    typedef struct packed {
        logic [31:0]      fPc;
        logic [31:0]      dInstr;
        logic [31:0]      dPc;
        logic [5:0]       eOp;
        logic [4:0]       eDstE;
        logic [4:0]       eDstM;
        logic [31:0]      eValA;
        logic [31:0]      eValB;
        logic [31:0]      eImm;
        logic [31:0]      ePc;
        logic             eValid;
        logic [CNT_W-1:0] stallCnt;
        logic [CNT_W-1:0] bubbleCnt;
    } outs_t;

    typedef struct {
        inp_t        in;
        logic [31:0] eFpc;
        logic [31:0] eDinstr;
        logic [31:0] eEpc;
        logic [5:0]  eOp;
        logic        eValid;
        int          eStall;
        int          eBubble;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             F_stall = 1'b0, D_stall = 1'b0, E_bubble = 1'b0;
    logic [31:0]      f_pc_next = '0, f_instr = '0;
    logic [31:0]      F_pc, D_instr, D_pc;
    logic [5:0]       d_op = '0;
    logic [4:0]       d_dstE = '0, d_dstM = '0;
    logic [31:0]      d_valA = '0, d_valB = '0, d_imm = '0;
    logic [5:0]       E_op;
    logic [4:0]       E_dstE, E_dstM;
    logic [31:0]      E_valA, E_valB, E_imm, E_pc;
    logic             E_valid;
    logic [CNT_W-1:0] stall_cnt, bubble_cnt;

    outs_t dutOut;
    outs_t model;
    int    vectors = 0;
    int    miscompares = 0;
    vec_t  tbl[6];

    pipe_stage_regs #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .F_stall(F_stall), .D_stall(D_stall), .E_bubble(E_bubble),
        .f_pc_next(f_pc_next), .f_instr(f_instr),
        .F_pc(F_pc), .D_instr(D_instr), .D_pc(D_pc),
        .d_op(d_op), .d_dstE(d_dstE), .d_dstM(d_dstM),
        .d_valA(d_valA), .d_valB(d_valB), .d_imm(d_imm),
        .E_op(E_op), .E_dstE(E_dstE), .E_dstM(E_dstM),
        .E_valA(E_valA), .E_valB(E_valB), .E_imm(E_imm), .E_pc(E_pc),
        .E_valid(E_valid), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    assign dutOut = {F_pc, D_instr, D_pc, E_op, E_dstE, E_dstM, E_valA, E_valB,
                     E_imm, E_pc, E_valid, stall_cnt, bubble_cnt};

    function automatic outs_t resetState();
        outs_t s;
        s = '0;
        s.fPc = RESET_PC;
        s.dPc = RESET_PC;
        s.ePc = RESET_PC;
        s.eOp = OP_NOP;
        s.eDstE = R_NONE;
        s.eDstM = R_NONE;
        return s;
    endfunction

    function automatic logic [CNT_W-1:0] satInc(logic [CNT_W-1:0] v, logic ev);
        int n;
        n = int'(v) + (ev ? 1 : 0);
        if (n > CNT_MAX) n = CNT_MAX;
        return CNT_W'(n);
    endfunction

    // One clock of the pipeline: each stage advances, holds, or is squashed.
    function automatic outs_t modelStep(outs_t s, inp_t in);
        outs_t n;
        n = s;
        n.fPc = in.fs ? s.fPc : in.pcNext;
        if (!in.ds) begin
            n.dInstr = in.instr;
            n.dPc    = s.fPc;
        end
        n.ePc = s.dPc;
        if (in.eb) begin
            {n.eOp, n.eDstE, n.eDstM} = {OP_NOP, R_NONE, R_NONE};
            {n.eValA, n.eValB, n.eImm} = '0;
            n.eValid = 1'b0;
        end else begin
            {n.eOp, n.eDstE, n.eDstM} = {in.op, in.dstE, in.dstM};
            {n.eValA, n.eValB, n.eImm} = {in.valA, in.valB, in.imm};
            n.eValid = 1'b1;
        end
        n.stallCnt  = satInc(s.stallCnt, in.ds);
        n.bubbleCnt = satInc(s.bubbleCnt, in.eb);
        return n;
    endfunction

    function automatic inp_t mk(logic fs, logic ds, logic eb, logic [31:0] pcNext,
                                logic [31:0] instr, logic [5:0] op, logic [4:0] dstM);
        inp_t r;
        r.fs = fs; r.ds = ds; r.eb = eb;
        r.pcNext = pcNext; r.instr = instr; r.op = op;
        r.dstE = 5'(op) ^ 5'h1F;
        r.dstM = dstM;
        r.valA = instr ^ 32'h0000_FFFF;
        r.valB = ~instr;
        r.imm  = {instr[15:0], instr[31:16]};
        return r;
    endfunction

    task automatic checkOutput(string name, outs_t exp);
        vectors++;
        if (dutOut !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h required %h", name, dutOut, exp);
        end
    endtask

    task automatic checkField(string name, logic [31:0] got, logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    task automatic applyStimulus(string name, inp_t in);
        outs_t nextState;
        {F_stall, D_stall, E_bubble} = {in.fs, in.ds, in.eb};
        f_pc_next = in.pcNext;
        f_instr   = in.instr;
        d_op = in.op; d_dstE = in.dstE; d_dstM = in.dstM;
        d_valA = in.valA; d_valB = in.valB; d_imm = in.imm;
        nextState = modelStep(model, in);
        @(posedge clk);
        model = nextState;
        #1;
        checkOutput(name, model);
    endtask

    // Reset is dropped mid-cycle and checked before any clock edge arrives.
    task automatic doReset(string name);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput(name, resetState());
        @(posedge clk);
        #1;
        checkOutput({name, " held"}, resetState());
        #2;
        rst_n = 1'b1;
        model = resetState();
    endtask

    initial begin
        int   hzCount;
        logic hz;
        inp_t rin;

        tbl[0] = '{mk(0,0,0,32'h44,32'h1111_1111,6'h01,5'h00), 32'h44, 32'h1111_1111, 32'h40, 6'h01, 1'b1, 0, 0};
        tbl[1] = '{mk(0,0,0,32'h48,32'h2222_2222,6'h02,5'h00), 32'h48, 32'h2222_2222, 32'h40, 6'h02, 1'b1, 0, 0};
        tbl[2] = '{mk(0,0,0,32'h4C,32'h3333_3333,6'h03,5'h00), 32'h4C, 32'h3333_3333, 32'h44, 6'h03, 1'b1, 0, 0};
        tbl[3] = '{mk(1,1,1,32'h50,32'h4444_4444,6'h05,5'h00), 32'h4C, 32'h3333_3333, 32'h48, OP_NOP, 1'b0, 1, 1};
        tbl[4] = '{mk(0,0,1,32'h50,32'h4444_4444,6'h06,5'h00), 32'h50, 32'h4444_4444, 32'h48, OP_NOP, 1'b0, 1, 2};
        tbl[5] = '{mk(0,1,0,32'h54,32'h5555_5555,6'h07,5'h00), 32'h54, 32'h4444_4444, 32'h4C, 6'h07, 1'b1, 2, 2};

        model = resetState();
        doReset("reset");

        for (int i = 0; i < 6; i++) begin
            applyStimulus($sformatf("table%0d model", i), tbl[i].in);
            checkField($sformatf("table%0d F_pc", i), F_pc, tbl[i].eFpc);
            checkField($sformatf("table%0d D_instr", i), D_instr, tbl[i].eDinstr);
            checkField($sformatf("table%0d E_pc", i), E_pc, tbl[i].eEpc);
            checkField($sformatf("table%0d E_op/valid", i), {25'h0, E_op, E_valid}, {25'h0, tbl[i].eOp, tbl[i].eValid});
            checkField($sformatf("table%0d counters", i), {24'h0, stall_cnt, bubble_cnt},
                       {24'h0, CNT_W'(tbl[i].eStall), CNT_W'(tbl[i].eBubble)});
        end

        // Load-use: the hazard unit is modelled in the loop from the E-stage outputs.
        doReset("reset before load-use");
        applyStimulus("load into E", mk(0,0,0,32'h44,32'hAAAA_0001,OP_LW,5'd5));
        checkField("lw in E", {22'h0, E_op, E_dstM}, {22'h0, OP_LW, 5'd5});
        hzCount = 0;
        for (int k = 0; k < 4; k++) begin
            hz = (E_op == OP_LW) && (E_dstM != R_NONE);
            if (hz) hzCount++;
            applyStimulus($sformatf("load-use cycle%0d", k),
                          mk(hz,hz,hz,32'h48 + 32'(4*k),32'hBBBB_0000 + 32'(k),OP_ADD,R_NONE));
            if (k == 0) begin
                checkField("load-use F_pc held", F_pc, 32'h44);
                checkField("load-use D_instr held", D_instr, 32'hAAAA_0001);
                checkField("load-use E_dstM cleared", {27'h0, E_dstM}, {27'h0, R_NONE});
            end
        end
        checkField("load-use stall cycles", 32'(hzCount), 32'd1);
        checkField("load-use counters", {24'h0, stall_cnt, bubble_cnt}, {24'h0, 4'd1, 4'd1});

        doReset("reset before all-high");
        for (int k = 0; k < 3; k++) begin
            applyStimulus($sformatf("all-high%0d", k), mk(1,1,1,32'h100,32'hCCCC_0000,OP_ADD,5'd3));
            checkField($sformatf("all-high%0d F_pc", k), F_pc, 32'h40);
            checkField($sformatf("all-high%0d D_instr", k), D_instr, 32'h0);
            checkField($sformatf("all-high%0d E_valid", k), {31'h0, E_valid}, 32'h0);
        end
        checkField("all-high counters", {24'h0, stall_cnt, bubble_cnt}, {24'h0, 4'd3, 4'd3});

        doReset("reset before saturation");
        for (int k = 0; k < 20; k++) begin
            applyStimulus($sformatf("sat%0d", k), mk(0,1,0,32'h200 + 32'(k),32'hDDDD_0000,OP_ADD,R_NONE));
            if (k == 14) checkField("sat reaches max", {28'h0, stall_cnt}, 32'd15);
        end
        checkField("sat stays at max", {24'h0, stall_cnt, bubble_cnt}, {24'h0, 4'd15, 4'd0});
        doReset("async reset during stall");

        for (int i = 0; i < 300; i++) begin
            rin.fs = ($urandom_range(0, 3) == 0);
            rin.ds = ($urandom_range(0, 3) == 0);
            rin.eb = ($urandom_range(0, 3) == 0);
            rin.pcNext = $urandom;
            rin.instr  = $urandom;
            rin.op   = 6'($urandom_range(0, 63));
            rin.dstE = 5'($urandom_range(0, 31));
            rin.dstM = 5'($urandom_range(0, 31));
            rin.valA = $urandom;
            rin.valB = $urandom;
            rin.imm  = $urandom;
            applyStimulus($sformatf("random%0d", i), rin);
            if (i == 150) doReset("random mid-stream reset");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
